// File: rtl/rti_capture_sequencer.sv
// Timed RTI capture controller: waits for an absolute start timestamp, then packs
// gapless din samples into 32-bit words and pushes {timestamp, word} into the capture FIFO.
module rti_capture_sequencer #(
    parameter int unsigned N_IN             = 4,
    parameter int unsigned SAMPLES_PER_WORD = 32 / N_IN,
    parameter int unsigned CNT_W            = 64,
    parameter int unsigned LEN_W            = 32
) (
    input  logic                clkx8,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_start_time,
    input  logic [LEN_W-1:0]    cmd_length,
    input  logic                abort,
    input  logic [CNT_W-1:0]    counter,
    input  logic [N_IN-1:0]     din,
    output logic                fifo_wr_en,
    output logic [CNT_W+31:0]   fifo_din,
    input  logic                fifo_full,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [15:0]         overflow_cnt
);

    localparam int unsigned SPW    = SAMPLES_PER_WORD;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SR_W   = WORD_W - N_IN;
    localparam int unsigned SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [CNT_W-1:0]    start_time_q;
    logic [LEN_W-1:0]    rem_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [SR_W-1:0]     word_sr;
    logic [CNT_W-1:0]    ts_q;

    logic accept;
    logic fire;
    logic take;
    logic word_end;
    logic last_word;
    logic stop_abort;

    // State register
    always_ff @(posedge clkx8) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and per-cycle control strobes; abort outranks the start-time match
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        fire       = 1'b0;
        take       = 1'b0;
        word_end   = 1'b0;
        last_word  = 1'b0;
        stop_abort = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                end else if (abort) begin
                    stop_abort = 1'b1;
                    state_d    = IDLE;
                end else if (counter >= start_time_q) begin
                    fire    = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // rem_q==0 here is the final-write cycle: abort no longer matters
                if (rem_q == '0) begin
                    state_d = IDLE;
                end else if (abort) begin
                    stop_abort = 1'b1;
                    state_d    = IDLE;
                end else begin
                    take = 1'b1;
                    if (slot_q == SLOT_W'(SPW - 1)) begin
                        word_end  = 1'b1;
                        last_word = (rem_q == LEN_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clkx8) begin
        if (reset) begin
            cmd_ready    <= 1'b1;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            overflow_cnt <= '0;
            start_time_q <= '0;
            rem_q        <= '0;
            slot_q       <= '0;
            word_sr      <= '0;
            ts_q         <= '0;
        end else begin
            cmd_ready  <= (state_d == IDLE);
            fifo_wr_en <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;

            if (accept) begin
                start_time_q <= cmd_start_time;
                rem_q        <= cmd_length;
                slot_q       <= '0;
                if (cmd_length == '0) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    busy <= 1'b1;
                end
            end

            if (fire) begin
                word_sr <= SR_W'(din);
                ts_q    <= counter;
                slot_q  <= SLOT_W'(1);
            end

            if (take) begin
                // Shift toward the MSB so sample 0 ends up in the top nibble
                word_sr <= SR_W'({word_sr, din});
                slot_q  <= word_end ? '0 : slot_q + SLOT_W'(1);
                if (slot_q == '0) begin
                    ts_q <= counter;
                end
            end

            if (word_end) begin
                rem_q <= rem_q - LEN_W'(1);
                if (fifo_full) begin
                    if (overflow_cnt != 16'hFFFF) begin
                        overflow_cnt <= overflow_cnt + 16'd1;
                    end
                end else begin
                    fifo_wr_en <= 1'b1;
                    fifo_din   <= {ts_q, word_sr, din};
                end
                if (last_word) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end

            if (stop_abort) begin
                done    <= 1'b1;
                aborted <= 1'b1;
                busy    <= 1'b0;
                rem_q   <= '0;
                slot_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rti_capture_sequencer.sv
// Directed bench for rti_capture_sequencer: timed start, packing, drops, abort, zero length, reset.
module tb_rti_capture_sequencer;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned SPW   = 8;
    localparam int unsigned CNT_W = 64;
    localparam int unsigned LEN_W = 32;

    logic               clkx8 = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CNT_W-1:0]   cmd_start_time;
    logic [LEN_W-1:0]   cmd_length;
    logic               abort;
    logic [CNT_W-1:0]   counter;
    logic [N_IN-1:0]    din;
    logic               fifo_wr_en;
    logic [CNT_W+31:0]  fifo_din;
    logic               fifo_full;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [15:0]        overflow_cnt;

    int                 checks = 0;
    int                 errors = 0;
    logic [CNT_W-1:0]   din_base;
    logic [CNT_W-1:0]   full_lo;
    logic [CNT_W-1:0]   full_hi;
    logic [CNT_W-1:0]   st;

    always #5 clkx8 = ~clkx8;

    rti_capture_sequencer #(
        .N_IN(N_IN), .SAMPLES_PER_WORD(SPW), .CNT_W(CNT_W), .LEN_W(LEN_W)
    ) dut (
        .clkx8(clkx8), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start_time(cmd_start_time), .cmd_length(cmd_length),
        .abort(abort), .counter(counter), .din(din),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .busy(busy), .done(done), .aborted(aborted), .overflow_cnt(overflow_cnt)
    );

    // One clkx8 cycle; the timestamp advances and din counts up from din_base
    task automatic tick();
        @(posedge clkx8);
        #1;
        counter   = counter + 64'd1;
        din       = N_IN'(counter - din_base);
        fifo_full = (counter >= full_lo) && (counter <= full_hi);
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return (k % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF;
    endfunction

    task automatic send_cmd(input logic [CNT_W-1:0] start, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 96'(cmd_ready), 96'(1));
        cmd_valid      = 1'b1;
        cmd_start_time = start;
        cmd_length     = len;
        tick();
        cmd_valid      = 1'b0;
    endtask

    // Cycle-by-cycle expectations from the first ARMED cycle up to one past completion
    task automatic run_window(input logic [CNT_W-1:0] t0, input int len, input int drop_word);
        logic [CNT_W-1:0] c;
        logic [CNT_W-1:0] t_end;
        logic             wr_exp;
        int               k;
        t_end = t0 + CNT_W'(SPW * len);
        while (counter <= t_end + 64'd1) begin
            c      = counter;
            wr_exp = 1'b0;
            k      = 0;
            if (c > t0 && ((c - t0) % SPW) == 0) begin
                k      = int'((c - t0) / SPW) - 1;
                wr_exp = (k < len) && (k + 1 != drop_word);
            end
            chk("wr_en", 96'(fifo_wr_en), 96'(wr_exp));
            chk("done", 96'(done), 96'(c == t_end));
            chk("busy", 96'(busy), 96'(c < t_end));
            chk("cmd_ready", 96'(cmd_ready), 96'(c > t_end));
            if (wr_exp) chk("fifo_din", fifo_din, {t0 + CNT_W'(SPW * k), pat(k)});
            if (c == t_end) chk("aborted_at_done", 96'(aborted), 96'(0));
            tick();
        end
    endtask

    initial begin
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_start_time = '0;
        cmd_length     = '0;
        abort          = 1'b0;
        counter        = '0;
        din            = '0;
        din_base       = '0;
        full_lo        = '1;
        full_hi        = '0;
        fifo_full      = 1'b0;
        st             = '0;
        tick();
        tick();
        chk("rst_cmd_ready", 96'(cmd_ready), 96'(1));
        chk("rst_wr_en", 96'(fifo_wr_en), 96'(0));
        chk("rst_fifo_din", fifo_din, 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_aborted", 96'(aborted), 96'(0));
        chk("rst_ovf", 96'(overflow_cnt), 96'(0));
        reset = 1'b0;
        tick();

        // Start at 1000, two words of counting nibbles
        counter  = 64'd990;
        din_base = 64'd1000;
        send_cmd(64'd1000, 32'd2);
        run_window(64'd1000, 2, 0);

        // Start time already in the past fires on the first ARMED cycle
        counter  = 64'd500;
        din_base = 64'd501;
        send_cmd(64'd5, 32'd1);
        run_window(64'd501, 1, 0);

        // Second of three words dropped on fifo_full
        st       = counter + 64'd4;
        din_base = st;
        full_lo  = st + 64'd15;
        full_hi  = st + 64'd16;
        send_cmd(st, 32'd3);
        run_window(st, 3, 2);
        chk("ovf_after_drop", 96'(overflow_cnt), 96'(1));
        full_lo  = '1;
        full_hi  = '0;

        // Abort in the final-write cycle still writes and reports a normal finish
        st       = counter + 64'd2;
        din_base = st;
        send_cmd(st, 32'd1);
        while (counter < st + 64'd8) tick();
        abort = 1'b1;
        chk("fin_abort_wr_en", 96'(fifo_wr_en), 96'(1));
        chk("fin_abort_din", fifo_din, {st, 32'h01234567});
        chk("fin_abort_done", 96'(done), 96'(1));
        chk("fin_abort_aborted", 96'(aborted), 96'(0));
        tick();
        abort = 1'b0;
        chk("fin_abort_ready", 96'(cmd_ready), 96'(1));
        chk("fin_abort_done_low", 96'(done), 96'(0));

        // Abort three cycles into CAPTURE
        st       = counter + 64'd3;
        din_base = st;
        send_cmd(st, 32'd4);
        while (counter < st + 64'd3) begin
            chk("abort_pre_wr_en", 96'(fifo_wr_en), 96'(0));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", 96'(done), 96'(1));
        chk("abort_aborted", 96'(aborted), 96'(1));
        chk("abort_busy", 96'(busy), 96'(0));
        chk("abort_ready", 96'(cmd_ready), 96'(1));
        chk("abort_wr_en", 96'(fifo_wr_en), 96'(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_post_wr_en", 96'(fifo_wr_en), 96'(0));
            chk("abort_post_done", 96'(done), 96'(0));
        end

        // Zero-length command
        send_cmd(counter + 64'd100, 32'd0);
        chk("len0_done", 96'(done), 96'(1));
        chk("len0_aborted", 96'(aborted), 96'(0));
        chk("len0_wr_en", 96'(fifo_wr_en), 96'(0));
        tick();
        chk("len0_ready", 96'(cmd_ready), 96'(1));
        chk("len0_done_low", 96'(done), 96'(0));

        // Reset in the middle of a capture
        st       = counter + 64'd2;
        din_base = st;
        send_cmd(st, 32'd2);
        while (counter < st + 64'd5) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_cmd_ready", 96'(cmd_ready), 96'(1));
        chk("mid_rst_wr_en", 96'(fifo_wr_en), 96'(0));
        chk("mid_rst_fifo_din", fifo_din, 96'(0));
        chk("mid_rst_busy", 96'(busy), 96'(0));
        chk("mid_rst_done", 96'(done), 96'(0));
        chk("mid_rst_aborted", 96'(aborted), 96'(0));
        chk("mid_rst_ovf", 96'(overflow_cnt), 96'(0));
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_wr_en", 96'(fifo_wr_en), 96'(0));
            chk("post_rst_busy", 96'(busy), 96'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
